// File: rtl/segment_vector_engine.sv
// Segment-vector lookup: 13 byte-indexed 256x10 tables, {shared,valid,id} per segment, plus a per-rule byte-mask table.
// Latency: search result registered 1 cycle after i_Key; installs are read-modify-write at the enable edge (read-before-write).
// Backpressure: none, one search and at most one install accepted every cycle. Optional mask table: define SEGVECT_MASK_EN.
module segment_vector_engine #(
    parameter int KWID    = 104,
    parameter int IDWID   = 8,
    parameter int SEGWID  = IDWID + 2,
    parameter int VTWID   = SEGWID * (KWID / IDWID),
    parameter int MASKWID = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KWID-1:0]          i_Key,
    output logic [VTWID-1:0]         o_Segment_Vector,
    output logic [MASKWID-1:0]       o_Mask_Data1,
    output logic [MASKWID-1:0]       o_Mask_Data2,
    output logic [MASKWID-1:0]       o_Mask_Data3,
    output logic [MASKWID-1:0]       o_Mask_Data4,
    output logic [MASKWID-1:0]       o_Mask_Data5,
    output logic [MASKWID-1:0]       o_Mask_Data6,
    output logic [MASKWID-1:0]       o_Mask_Data7,
    output logic [MASKWID-1:0]       o_Mask_Data8,
    output logic [MASKWID-1:0]       o_Mask_Data9,
    output logic [MASKWID-1:0]       o_Mask_Data10,
    output logic [MASKWID-1:0]       o_Mask_Data11,
    output logic [MASKWID-1:0]       o_Mask_Data12,
    output logic [MASKWID-1:0]       o_Mask_Data13,
    input  logic [KWID+MASKWID-1:0]  i_Set_Data,
    input  logic [IDWID-1:0]         i_Set_ID,
    input  logic                     i_Set_Segment_Enable
);

    localparam int NSEG  = KWID / IDWID;
    localparam int DEPTH = 1 << IDWID;
    localparam int VBIT  = IDWID;       // valid bit position within an entry
    localparam int SBIT  = IDWID + 1;   // shared bit position within an entry

    logic [VTWID-1:0]   vec_q;
    logic [VTWID-1:0]   vec_d;
    logic [MASKWID-1:0] mask_out [NSEG];

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        // Segment g = segment k+1; segment 1 owns the most significant key byte and vector field.
        logic [SEGWID-1:0] tbl_q [DEPTH];
        logic [IDWID-1:0]  srch_addr;
        logic [IDWID-1:0]  set_addr;
        logic [SEGWID-1:0] srch_rd;
        logic [SEGWID-1:0] set_rd;
        logic [SEGWID-1:0] fld_d;
        logic [SEGWID-1:0] tbl_wr_d;

        assign srch_addr = i_Key[KWID-1-IDWID*g -: IDWID];
        assign set_addr  = i_Set_Data[KWID-1-IDWID*g -: IDWID];
        assign srch_rd   = tbl_q[srch_addr];
        assign set_rd    = tbl_q[set_addr];

        // Search field: invalid entries are forced to zero; install entry: first writer keeps the ID, a different ID marks shared.
        always_comb begin
            fld_d    = '0;
            tbl_wr_d = set_rd;
            if (srch_rd[VBIT]) begin
                fld_d = srch_rd;
            end
            if (!set_rd[VBIT]) begin
                tbl_wr_d = {1'b0, 1'b1, i_Set_ID};
            end else if (set_rd[IDWID-1:0] != i_Set_ID) begin
                tbl_wr_d[SBIT] = 1'b1;
            end
        end

        // Table storage: full clear on reset, one read-modify-write per install strobe.
        always_ff @(posedge clk) begin
            if (rst) begin
                tbl_q <= '{default: '0};
            end else if (i_Set_Segment_Enable) begin
                tbl_q[set_addr] <= tbl_wr_d;
            end
        end

        assign vec_d[VTWID-1-SEGWID*g -: SEGWID] = fld_d;
    end

    // Registered segment vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign o_Segment_Vector = vec_q;

`ifdef SEGVECT_MASK_EN
    logic [MASKWID-1:0] mask_q [DEPTH];
    logic [MASKWID-1:0] mask_wr_d;

    assign mask_wr_d = i_Set_Data[KWID+MASKWID-1 -: MASKWID];

    // Per-rule byte mask, last install of an ID wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '{default: '0};
        end else if (i_Set_Segment_Enable) begin
            mask_q[i_Set_ID] <= mask_wr_d;
        end
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_mask
        // Mask lookup is combinational off the registered vector, so it tracks installs made after the search.
        logic [IDWID-1:0] vec_id;
        assign vec_id      = vec_q[VTWID-3-SEGWID*g -: IDWID];
        assign mask_out[g] = mask_q[vec_id];
    end
`else
    logic unused_mask_bits;
    assign unused_mask_bits = ^i_Set_Data[KWID+MASKWID-1:KWID];

    for (genvar g = 0; g < NSEG; g++) begin : g_mask
        assign mask_out[g] = '0;
    end
`endif

    assign o_Mask_Data1  = mask_out[0];
    assign o_Mask_Data2  = mask_out[1];
    assign o_Mask_Data3  = mask_out[2];
    assign o_Mask_Data4  = mask_out[3];
    assign o_Mask_Data5  = mask_out[4];
    assign o_Mask_Data6  = mask_out[5];
    assign o_Mask_Data7  = mask_out[6];
    assign o_Mask_Data8  = mask_out[7];
    assign o_Mask_Data9  = mask_out[8];
    assign o_Mask_Data10 = mask_out[9];
    assign o_Mask_Data11 = mask_out[10];
    assign o_Mask_Data12 = mask_out[11];
    assign o_Mask_Data13 = mask_out[12];

endmodule

// File: tb/tb_segment_vector_engine.sv
// Bench for segment_vector_engine: directed steps plus randomized installs/searches against a rule-list reference model.
// Expected vector is derived by scanning installed rules in order (first matching rule owns the byte, later distinct IDs mark shared).
// Mask expectations follow SEGVECT_MASK_EN; with it undefined all mask outputs must be zero.
module tb_segment_vector_engine;

`ifdef SEGVECT_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    typedef struct packed {
        logic [103:0] key;
        logic [7:0]   id;
    } rule_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [103:0]  i_Key;
    logic [129:0]  o_Segment_Vector;
    logic [12:0]   mk [13];
    logic [116:0]  i_Set_Data;
    logic [7:0]    i_Set_ID;
    logic          i_Set_Segment_Enable;

    rule_t         rules[$];
    logic [12:0]   mask_m [256];
    logic [129:0]  ev;
    logic [12:0]   em [13];
    int            comps = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    segment_vector_engine dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_Key                (i_Key),
        .o_Segment_Vector     (o_Segment_Vector),
        .o_Mask_Data1         (mk[0]),
        .o_Mask_Data2         (mk[1]),
        .o_Mask_Data3         (mk[2]),
        .o_Mask_Data4         (mk[3]),
        .o_Mask_Data5         (mk[4]),
        .o_Mask_Data6         (mk[5]),
        .o_Mask_Data7         (mk[6]),
        .o_Mask_Data8         (mk[7]),
        .o_Mask_Data9         (mk[8]),
        .o_Mask_Data10        (mk[9]),
        .o_Mask_Data11        (mk[10]),
        .o_Mask_Data12        (mk[11]),
        .o_Mask_Data13        (mk[12]),
        .i_Set_Data           (i_Set_Data),
        .i_Set_ID             (i_Set_ID),
        .i_Set_Segment_Enable (i_Set_Segment_Enable)
    );

    // Reference: scan the rule list in install order for a segment byte.
    function automatic logic [9:0] exp_field(input int k, input logic [7:0] b);
        logic       found = 1'b0;
        logic       sh    = 1'b0;
        logic [7:0] id    = 8'h00;
        foreach (rules[i]) begin
            if (rules[i].key[103-8*k -: 8] == b) begin
                if (!found) begin
                    found = 1'b1;
                    id    = rules[i].id;
                end else if (rules[i].id != id) begin
                    sh = 1'b1;
                end
            end
        end
        return found ? {sh, 1'b1, id} : 10'h000;
    endfunction

    function automatic logic [129:0] exp_vec(input logic [103:0] key);
        logic [129:0] v = '0;
        for (int k = 0; k < 13; k++) begin
            v[129-10*k -: 10] = exp_field(k, key[103-8*k -: 8]);
        end
        return v;
    endfunction

    function automatic logic [103:0] rand_key();
        logic [103:0] v = '0;
        for (int k = 0; k < 13; k++) begin
            v[103-8*k -: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'(8'h40 + $urandom_range(0, 5));
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        comps++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model, then check vector and all masks 1 time unit after the edge.
    task automatic cyc(input logic r, input logic en, input logic [103:0] sk, input logic [12:0] sm,
                       input logic [7:0] sid, input logic [103:0] key);
        rst                  = r;
        i_Set_Segment_Enable = en;
        i_Set_Data           = {sm, sk};
        i_Set_ID             = sid;
        i_Key                = key;
        if (r) begin
            ev = '0;
            rules.delete();
            foreach (mask_m[i]) mask_m[i] = '0;
        end else begin
            ev = exp_vec(key);              // search sees pre-install contents
            if (en) begin
                rules.push_back({sk, sid});
                mask_m[sid] = sm;           // mask output reads the table after the edge
            end
        end
        for (int k = 0; k < 13; k++) begin
            em[k] = MASK_ON ? mask_m[ev[127-10*k -: 8]] : 13'h0000;
        end
        @(posedge clk);
        #1;
        chk("vector", o_Segment_Vector, ev);
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("mask%0d", k + 1), {117'd0, mk[k]}, {117'd0, em[k]});
        end
    endtask

    initial begin
        logic [103:0] key1;
        logic [103:0] kx;
        logic [103:0] ks;
        logic [129:0] v;
        logic [12:0]  m5;
        key1 = 104'h40_5B_6A_00_A8_68_00_00_FF_FF_FF_FF_FF;

        rst = 1'b1; i_Key = '0; i_Set_Data = '0; i_Set_ID = '0; i_Set_Segment_Enable = 1'b0;

        // Reset and an idle search.
        cyc(1'b1, 1'b0, '0, '0, 8'h00, key1);
        cyc(1'b1, 1'b0, '0, '0, 8'h00, key1);
        chk("reset_vector", o_Segment_Vector, '0);
        cyc(1'b0, 1'b0, '0, '0, 8'h00, key1);
        chk("empty_search", o_Segment_Vector, '0);

        // Single install of ID 00 with mask 0x0260, then search it.
        cyc(1'b0, 1'b1, key1, 13'h0260, 8'h00, '0);
        cyc(1'b0, 1'b0, '0, '0, 8'h00, key1);
        v = {13{10'h100}};
        chk("id0_fields", o_Segment_Vector, v);
        m5 = MASK_ON ? 13'h0260 : 13'h0000;
        chk("id0_mask5", {117'd0, mk[4]}, {117'd0, m5});

        // Install and search the same new key in one cycle: old (empty) result, then new one.
        kx = {13{8'hC1}};
        cyc(1'b0, 1'b1, kx, 13'h1FFF, 8'h11, kx);
        chk("rbw_old", o_Segment_Vector, '0);
        cyc(1'b0, 1'b0, '0, '0, 8'h00, kx);
        v = {13{10'h111}};
        chk("rbw_new", o_Segment_Vector, v);

        // Same ID installed on consecutive cycles must not become shared.
        kx = {13{8'hD4}};
        cyc(1'b0, 1'b1, kx, 13'h0F0F, 8'h04, '0);
        cyc(1'b0, 1'b1, kx, 13'h0F0F, 8'h04, '0);
        cyc(1'b0, 1'b0, '0, '0, 8'h00, kx);
        v = {13{10'h104}};
        chk("same_id_repeat", o_Segment_Vector, v);

        // A different ID on an owned byte keeps the first ID and marks shared.
        cyc(1'b0, 1'b1, kx, 13'h0001, 8'h09, '0);
        cyc(1'b0, 1'b0, '0, '0, 8'h00, kx);
        v = {13{10'h304}};
        chk("shared_first_wins", o_Segment_Vector, v);

        // Randomized installs and searches, often colliding on bytes and IDs.
        for (int n = 0; n < 250; n++) begin
            logic         en;
            logic [103:0] sk;
            en = ($urandom_range(0, 9) < 4);
            sk = rand_key();
            if (rules.size() > 0 && $urandom_range(0, 1) == 1) begin
                ks = rules[$urandom_range(0, rules.size() - 1)].key;
            end else begin
                ks = rand_key();
            end
            if ($urandom_range(0, 7) == 0) ks = sk;
            cyc(1'b0, en, sk, 13'($urandom), 8'($urandom_range(0, 15)), ks);
        end

        // Reset during an install discards the write.
        kx = {13{8'hE7}};
        cyc(1'b1, 1'b1, kx, 13'h1234, 8'h07, kx);
        chk("reset_during_install", o_Segment_Vector, '0);
        cyc(1'b0, 1'b0, '0, '0, 8'h00, kx);
        chk("discarded_install", o_Segment_Vector, '0);
        cyc(1'b0, 1'b0, '0, '0, 8'h00, key1);
        chk("cleared_after_reset", o_Segment_Vector, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

endmodule

// File: doc/segment_vector_engine.md
# segment_vector_engine

Segment-vector lookup engine for an FPGA TCAM front end. A 104-bit search key is split into 13 byte segments; each segment indexes its own 256-entry table holding a 10-bit {status, rule ID} word. The 13 words are concatenated into a 130-bit segment vector for the downstream match stage. A per-rule mask table returns the stored 13-bit byte mask of the rule ID reported by each segment.

## Interface
- KWID, 104, key width; must equal 13*IDWID.
- IDWID, 8, rule ID width and segment (byte) width; table depth 2^IDWID = 256.
- SEGWID, IDWID+2, per-segment vector field width.
- VTWID, SEGWID*(KWID/IDWID) = 130, segment vector width.
- MASKWID, 13, byte-mask width (one bit per segment).
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_Key  in  KWID  search key.
- o_Segment_Vector  out  VTWID  registered lookup result.
- o_Mask_Data1 .. o_Mask_Data13  out  MASKWID each  mask of the ID reported by segment 1..13.
- i_Set_Data  in  KWID+MASKWID  {mask[12:0], key[103:0]} of the rule being installed.
- i_Set_ID  in  IDWID  rule ID being installed.
- i_Set_Segment_Enable  in  1  install strobe, one write per high cycle.

## Operation
- Segment k (k=1..13, k=1 most significant): key byte i_Key[KWID-1-8(k-1) -: 8]; vector field o_Segment_Vector[VTWID-1-10(k-1) -: 10]; mask output o_Mask_Datak.
- Entry format: bit 9 = shared, bit 8 = valid, bits 7:0 = ID.
- Install (enable high): for each segment k, address = key byte k of i_Set_Data[103:0], read-modify-write:
  - entry invalid -> {0,1,i_Set_ID};
  - entry valid, stored ID = i_Set_ID -> unchanged;
  - entry valid, other ID -> shared set, ID kept (first writer wins).
- Install ignores the mask bits for table addressing: masked bytes are written at their literal byte value.
- Mask table: 256 x 13. On install, mask[i_Set_ID] <= i_Set_Data[116:104]. Mask bit 12 corresponds to segment 1.
- Search: each cycle every segment reads table[key byte]. Invalid entries read as 10'h000. The result is registered into o_Segment_Vector.
- o_Mask_Datak = mask[ID field of segment k of o_Segment_Vector], read combinationally from the registered vector.
- Reset clears all status bits, all IDs, the mask table and the vector register.

## Timing
- Search latency 1 cycle: i_Key sampled at edge N, o_Segment_Vector and o_Mask_Data* valid after edge N and held until edge N+1.
- Install takes effect at the enable edge; a search in that same cycle returns pre-write contents (read-before-write). Searches from the next cycle see the new data.
- Back-to-back installs on consecutive cycles are legal. Same-ID repeats do not set shared.
- rst dominates install and search. All outputs are 0 after the reset edge. A reset during an install discards the write.

## Configuration
- SEGVECT_MASK_EN defined: mask table and o_Mask_Data1..13 implemented as above.
- SEGVECT_MASK_EN not defined: no mask storage; o_Mask_Data1..13 tied to 0; segment vector behaviour unchanged.

## Test plan
- Reset, then search any key -> vector all zero, masks zero.
- Install ID 00, key 40_5B_6A_00_A8_68_00_00_FF_FF_FF_FF_FF, mask 0x0260; search the same key next cycle -> every field {01,00}; o_Mask_Data5 = 0x0260.
- Install IDs 00..09 in order using the standard 10-rule set (R2 40_5B_6B_3A_40_5B_6C_00_FF.., R3 40_5B_6B_3C_FB_E2_E9_00_FF.., etc., one idle cycle between installs), then search R3:
  - fields 1-2 -> {11,00};
  - field 3 -> {11,01};
  - fields 4-7 -> {01,02};
  - field 8 -> {11,00};
  - fields 9-13 -> {11,00}.
- Same set, search R10 key C0_97_0B_29_0F_00_78_04_FF.. -> fields {11,03}x3, {01,09}, {11,05}, {11,03}, {01,09}, {01,09}, {11,00}x5.
- Install ID 04 twice on consecutive cycles -> its unique bytes remain {01,04}, not shared.
- Install and search the same key in one cycle -> old vector returned. Next cycle -> new vector returned.
